// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared encodings for the BRAM access controller.
// Width-mode codes, the bit positions of the control fields that ride on
// the RAM's write-data bus, and the read-FSM state type.
package bram_ctrl_pkg;

    // Element width modes (WR_MODE / RD_MODE values)
    localparam int MODE_32 = 0;
    localparam int MODE_16 = 1;
    localparam int MODE_8  = 2;

    // Control fields carried on bram_wr_data
    localparam int RD_SEL_LSB = 24;
    localparam int WR_SEL_LSB = 16;
    localparam int WR_EN_BIT  = 20;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Element select within a 32-bit word from the low byte-address bits
    function automatic logic [1:0] elem_sel(input int mode, input logic [1:0] lo);
        case (mode)
            MODE_16: elem_sel = {1'b0, lo[1]};
            MODE_8:  elem_sel = lo;
            default: elem_sel = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bram_ctrl_pack.sv
// bram_ctrl_pack: combinational field packing for the BRAM fabric port.
// Builds the write field (data, element select, write enable), the read
// element-select field, and masks returned RAM data to the read width.
module bram_ctrl_pack
    import bram_ctrl_pkg::*;
#(
    parameter int WR_MODE = 2,
    parameter int RD_MODE = 2
) (
    input  logic [1:0]  wr_lo,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_lo,
    input  logic [31:0] rd_raw,
    output logic [31:0] wr_field,
    output logic [31:0] rd_field,
    output logic [31:0] rd_masked
);

    // Narrow modes leave some address/data bits unused by design
    logic unused_pack;
    assign unused_pack = ^{wr_lo, wr_data, rd_lo, rd_raw};

    // Write field: enable bit, element select and element data
    always_comb begin
        wr_field                    = '0;
        wr_field[WR_EN_BIT]         = 1'b1;
        wr_field[WR_SEL_LSB +: 2]   = elem_sel(WR_MODE, wr_lo);
        wr_field[15:0]              = (WR_MODE == MODE_16) ? wr_data : {8'h00, wr_data[7:0]};
    end

    // Read field: only the element select; disjoint from every write bit
    always_comb begin
        rd_field                  = '0;
        rd_field[RD_SEL_LSB +: 2] = elem_sel(RD_MODE, rd_lo);
    end

    // RAM returns the selected element low-aligned; clear everything above it
    always_comb begin
        if (RD_MODE == MODE_16)
            rd_masked = {16'h0000, rd_raw[15:0]};
        else if (RD_MODE == MODE_8)
            rd_masked = {24'h000000, rd_raw[7:0]};
        else
            rd_masked = rd_raw;
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// bram_access_ctrl: valid/ready front end for a 1 KB RAM fabric port.
// Writes are always accepted and issued one cycle after the handshake;
// reads run through a small FSM that waits out the RAM latency
// (1 + OPT_REG cycles after the address is presented) and holds the
// response until it is taken.
// Optional macro BRAM_CTRL_HAZARD_STALL_EN: on a same-word write/read
// collision, the read is held off one cycle so it observes the write.
module bram_access_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int WR_MODE = 2,
    parameter int RD_MODE = 2,
    parameter int OPT_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [9:0]  rd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [7:0]  bram_wr_addr,
    output logic [7:0]  bram_rd_addr,
    output logic [31:0] bram_wr_data,
    input  logic [31:0] bram_rd_data
);

    if ((WR_MODE != MODE_16) && (WR_MODE != MODE_8)) begin : g_bad_wr_mode
        $error("bram_access_ctrl: WR_MODE must be 1 (16-bit) or 2 (8-bit)");
    end

    localparam logic [1:0] LAT_INIT = 2'(1 + OPT_REG);

    rd_state_t   rd_state;
    logic [1:0]  lat_cnt;
    logic        collide;
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] wr_field;
    logic [31:0] rd_field;
    logic [31:0] rd_masked;

    bram_ctrl_pack #(
        .WR_MODE (WR_MODE),
        .RD_MODE (RD_MODE)
    ) u_pack (
        .wr_lo     (wr_addr[1:0]),
        .wr_data   (wr_data),
        .rd_lo     (rd_addr[1:0]),
        .rd_raw    (bram_rd_data),
        .wr_field  (wr_field),
        .rd_field  (rd_field),
        .rd_masked (rd_masked)
    );

`ifdef BRAM_CTRL_HAZARD_STALL_EN
    // Same word on both sides: let the write go first, read retries next cycle
    assign collide = wr_valid && rd_valid && (wr_addr[9:2] == rd_addr[9:2]);
`else
    assign collide = 1'b0;
`endif

    assign wr_ready = 1'b1;
    assign wr_fire  = wr_valid;
    assign rd_ready = (rd_state == R_IDLE) && !collide;
    assign rd_fire  = rd_valid && rd_ready;

    // Fabric port registers; write enable and selects live for one cycle only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_wr_addr <= '0;
            bram_rd_addr <= '0;
            bram_wr_data <= '0;
        end else begin
            bram_wr_data <= (wr_fire ? wr_field : 32'h0) | (rd_fire ? rd_field : 32'h0);
            if (wr_fire) bram_wr_addr <= wr_addr[9:2];
            if (rd_fire) bram_rd_addr <= rd_addr[9:2];
        end
    end

    // Read FSM: issue, wait out RAM latency, hold response until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_fire) begin
                        rd_state <= R_WAIT;
                        lat_cnt  <= LAT_INIT;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_data  <= rd_masked;
                        rsp_valid <= 1'b1;
                        rd_state  <= R_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                R_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rd_state  <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb_bram_access_ctrl: directed scoreboard bench for bram_access_ctrl.
// DUT 0: WR_MODE=2, RD_MODE=1, OPT_REG=0.  DUT 1: WR_MODE=1, RD_MODE=0, OPT_REG=1.
// Each DUT drives a behavioural 256x32 RAM that honours the write/read
// select fields and returns the selected element low-aligned.
module tb_bram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [1:0][9:0]  wr_addr, rd_addr;
    logic [1:0][15:0] wr_data;
    logic [1:0][31:0] rsp_data, bram_wr_data, bram_rd_data;
    logic [1:0][7:0]  bram_wr_addr, bram_rd_addr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    bram_access_ctrl #(.WR_MODE(2), .RD_MODE(1), .OPT_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_addr(rd_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .bram_wr_addr(bram_wr_addr[0]), .bram_rd_addr(bram_rd_addr[0]),
        .bram_wr_data(bram_wr_data[0]), .bram_rd_data(bram_rd_data[0])
    );

    bram_access_ctrl #(.WR_MODE(1), .RD_MODE(0), .OPT_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_addr(rd_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .bram_wr_addr(bram_wr_addr[1]), .bram_rd_addr(bram_rd_addr[1]),
        .bram_wr_data(bram_wr_data[1]), .bram_rd_data(bram_rd_data[1])
    );

    function automatic logic [31:0] ram_view(input logic [31:0] w, input logic [1:0] s, input int m);
        case (m)
            1:       return w >> (s[0] * 16);
            2:       return w >> (s * 8);
            default: return w;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_ram
        localparam int WM = (k == 0) ? 2 : 1;
        localparam int RM = (k == 0) ? 1 : 0;
        localparam int OR = (k == 0) ? 0 : 1;
        logic [31:0] mem [256];
        logic [31:0] w1, w2;
        logic [1:0]  s1, s2;
        initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        always @(posedge clk) begin
            w1 <= mem[bram_rd_addr[k]];
            s1 <= bram_wr_data[k][25:24];
            w2 <= w1;
            s2 <= s1;
            if (bram_wr_data[k][20]) begin
                if (WM == 1)
                    mem[bram_wr_addr[k]][bram_wr_data[k][16] * 16 +: 16] <= bram_wr_data[k][15:0];
                else
                    mem[bram_wr_addr[k]][bram_wr_data[k][17:16] * 8 +: 8] <= bram_wr_data[k][7:0];
            end
        end
        assign bram_rd_data[k] = ram_view((OR == 1) ? w2 : w1, (OR == 1) ? s2 : s1, RM);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts just after a negedge; ends at the negedge where the write is on the port
    task automatic wr_go(input int d, input logic [9:0] a, input logic [15:0] v);
        wr_valid[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
        #1 chk("wr_ready", 32'(wr_ready[d]), 32'd1);
        @(negedge clk);
        wr_valid[d] = 1'b0;
    endtask

    // Ends at the negedge of the cycle after the read handshake
    task automatic rd_go(input int d, input logic [9:0] a, input logic [31:0] e, input bit push);
        int n;
        n = 0;
        rd_valid[d] = 1'b1; rd_addr[d] = a;
        if (push) exp_q.push_back(e);
        #1;
        while (!rd_ready[d] && n < 20) begin @(negedge clk); #1; n++; end
        chk("rd_accept", 32'(rd_ready[d]), 32'd1);
        @(negedge clk);
        rd_valid[d] = 1'b0; wr_valid[d] = 1'b0;
    endtask

    // Called at the negedge one cycle after the handshake; k counts cycles from it
    task automatic rsp_wait(input int d, input int lat, input int hold, input bit cmp);
        int k;
        logic [31:0] e;
        k = 1;
        e = 32'h0;
        rsp_ready[d] = (hold == 0);
        while (!rsp_valid[d] && k < 20) begin @(negedge clk); k++; end
        chk("rsp_latency", 32'(k), 32'(lat));
        if (cmp) begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data[d], e);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_data", rsp_data[d], e);
            chk("hold_rd_ready", 32'(rd_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid[d]), 32'd0);
        chk("rd_ready_after", 32'(rd_ready[d]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0; wr_valid = '0; rd_valid = '0; rsp_ready = '1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_data", rsp_data[0], 32'd0);
        chk("rst_bram_wr_addr", 32'(bram_wr_addr[0]), 32'd0);
        chk("rst_bram_rd_addr", 32'(bram_rd_addr[0]), 32'd0);
        chk("rst_bram_wr_data", bram_wr_data[0], 32'd0);
        chk("rst_b_bram_wr_data", bram_wr_data[1], 32'd0);
        chk("rst_rd_ready", 32'(rd_ready[0]), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready[0]), 32'd1);

        // Release and write on the very first edge after it: word 0 = 0x12345678
        rst_n = 1'b1;
        wr_go(0, 10'h000, 16'h0078);
        chk("first_wr_issued", 32'(bram_wr_data[0][20]), 32'd1);
        wr_go(0, 10'h001, 16'h0056);
        wr_go(0, 10'h002, 16'h0034);
        wr_go(0, 10'h003, 16'h0012);
        chk("wr8_sel3", 32'(bram_wr_data[0][17:16]), 32'd3);

        // 16-bit read of upper half
        rd_go(0, 10'h002, 32'h0000_1234, 1'b1);
        chk("rd16_sel", 32'(bram_wr_data[0][25:24]), 32'd1);
        chk("rd_no_we", 32'(bram_wr_data[0][20]), 32'd0);
        rsp_wait(0, 3, 0, 1'b1);

        // Byte write, then read of the same word on the next cycle
        wr_go(0, 10'h007, 16'h5AA5);
        chk("wr8_addr", 32'(bram_wr_addr[0]), 32'h01);
        chk("wr8_sel", 32'(bram_wr_data[0][17:16]), 32'd3);
        chk("wr8_we", 32'(bram_wr_data[0][20]), 32'd1);
        chk("wr8_data", 32'(bram_wr_data[0][7:0]), 32'hA5);
        rd_go(0, 10'h006, 32'h0000_A500, 1'b1);
        chk("wr8_we_clear", 32'(bram_wr_data[0][20]), 32'd0);
        chk("raw_rd_addr", 32'(bram_rd_addr[0]), 32'h01);
        chk("raw_rd_sel", 32'(bram_wr_data[0][25:24]), 32'd1);
        rsp_wait(0, 3, 0, 1'b1);

        // Backpressure: response held 5 cycles
        rd_go(0, 10'h000, 32'h0000_5678, 1'b1);
        rsp_wait(0, 3, 5, 1'b1);

        // Read and write to different words in the same cycle
        wr_valid[0] = 1'b1; wr_addr[0] = 10'h00C; wr_data[0] = 16'h0077;
        rd_go(0, 10'h002, 32'h0000_1234, 1'b1);
        chk("dual_we", 32'(bram_wr_data[0][20]), 32'd1);
        chk("dual_wr_addr", 32'(bram_wr_addr[0]), 32'h03);
        chk("dual_rd_sel", 32'(bram_wr_data[0][25:24]), 32'd1);
        chk("dual_rd_addr", 32'(bram_rd_addr[0]), 32'h00);
        rsp_wait(0, 3, 0, 1'b1);

        // Same-word collision
        wr_valid[0] = 1'b1; wr_addr[0] = 10'h010; wr_data[0] = 16'h003C;
        rd_valid[0] = 1'b1; rd_addr[0] = 10'h010;
`ifdef BRAM_CTRL_HAZARD_STALL_EN
        exp_q.push_back(32'h0000_003C);
        #1 chk("coll_rd_stall", 32'(rd_ready[0]), 32'd0);
        @(negedge clk);
        wr_valid[0] = 1'b0;
        #1 chk("coll_we", 32'(bram_wr_data[0][20]), 32'd1);
        chk("coll_wr_addr", 32'(bram_wr_addr[0]), 32'h04);
        chk("coll_rd_retry", 32'(rd_ready[0]), 32'd1);
        @(negedge clk);
        rd_valid[0] = 1'b0;
        rsp_wait(0, 3, 0, 1'b1);
`else
        #1 chk("coll_rd_ready", 32'(rd_ready[0]), 32'd1);
        @(negedge clk);
        wr_valid[0] = 1'b0; rd_valid[0] = 1'b0;
        chk("coll_we", 32'(bram_wr_data[0][20]), 32'd1);
        chk("coll_rd_addr", 32'(bram_rd_addr[0]), 32'h04);
        rsp_wait(0, 3, 0, 1'b0);
`endif

        // DUT 1: 16-bit writes, 32-bit read with output register
        wr_go(1, 10'h000, 16'h5678);
        chk("b_wr_sel0", 32'(bram_wr_data[1][17:16]), 32'd0);
        chk("b_wr_data0", 32'(bram_wr_data[1][15:0]), 32'h5678);
        wr_go(1, 10'h002, 16'h1234);
        chk("b_wr_sel1", 32'(bram_wr_data[1][17:16]), 32'd1);
        chk("b_wr_data1", 32'(bram_wr_data[1][15:0]), 32'h1234);
        rd_go(1, 10'h000, 32'h1234_5678, 1'b1);
        chk("b_rd_sel", 32'(bram_wr_data[1][25:24]), 32'd0);
        rsp_wait(1, 4, 0, 1'b1);

        // Reset during R_WAIT drops the read
        rd_go(0, 10'h000, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("mid_rst_wr_addr", 32'(bram_wr_addr[0]), 32'd0);
        chk("mid_rst_rd_addr", 32'(bram_rd_addr[0]), 32'd0);
        chk("mid_rst_wr_data", bram_wr_data[0], 32'd0);
        chk("mid_rst_rd_ready", 32'(rd_ready[0]), 32'd1);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen = seen | rsp_valid[0]; end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
        chk("post_rst_wr_data", bram_wr_data[0], 32'd0);
        rd_go(0, 10'h002, 32'h0000_1234, 1'b1);
        rsp_wait(0, 3, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
